niosii_tcm_arbiter: RTL

NIOSII_TCM_ARBITER -- requirements
Module: niosII_tcm_arbiter

---
 rtl/niosii_tcm_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/niosii_tcm_arbiter.sv
// Two-master round-robin arbiter in front of a single-port tightly coupled
// memory with a fixed read latency of one cycle.
//
// Ports:
//   clk, reset                      single clock, synchronous active-high reset
//   m0_* / m1_*                     Avalon-MM style slave ports (address,
//                                   byteenable, read, write, writedata in;
//                                   waitrequest, readdata, readdatavalid out)
//   tcm_address/byteenable/         memory port driven from the granted master
//   chipselect/write/writedata
//   tcm_clken                       memory clock enable, high out of reset
//   tcm_readdata                    memory output, valid one cycle after address
module niosii_tcm_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] tcm_address,
    output logic [BE_W-1:0]   tcm_byteenable,
    output logic              tcm_chipselect,
    output logic              tcm_write,
    output logic [DATA_W-1:0] tcm_writedata,
    output logic              tcm_clken,
    input  logic [DATA_W-1:0] tcm_readdata
);

    logic req0_s;
    logic req1_s;
    logic gnt0_s;
    logic gnt1_s;

    // last_grant: 1'b1 means m1 was granted last, so m0 wins the next contention
    logic last_grant_q;
    logic last_grant_d;
    logic rd_pending_q;
    logic rd_pending_d;
    logic rd_owner_q;
    logic rd_owner_d;

    // Request detection and round-robin grant (nothing is granted during reset)
    always_comb begin
        req0_s = m0_read | m0_write;
        req1_s = m1_read | m1_write;
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (req0_s && req1_s) begin
            gnt0_s = last_grant_q;
            gnt1_s = ~last_grant_q;
        end else begin
            gnt0_s = req0_s;
            gnt1_s = req1_s;
        end
    end

    // Memory-port mux; a simultaneous read+write is issued as a write
    always_comb begin
        tcm_address    = m0_address;
        tcm_byteenable = m0_byteenable;
        tcm_writedata  = m0_writedata;
        if (gnt1_s) begin
            tcm_address    = m1_address;
            tcm_byteenable = m1_byteenable;
            tcm_writedata  = m1_writedata;
        end else begin
            tcm_address    = m0_address;
            tcm_byteenable = m0_byteenable;
            tcm_writedata  = m0_writedata;
        end
        tcm_chipselect = gnt0_s | gnt1_s;
        tcm_write      = (gnt0_s & m0_write) | (gnt1_s & m1_write);
        tcm_clken      = ~reset;
    end

    // Handshake and read-return outputs
    always_comb begin
        m0_waitrequest   = reset | (req0_s & ~gnt0_s);
        m1_waitrequest   = reset | (req1_s & ~gnt1_s);
        // Gating with reset drops a read whose return cycle coincides with reset
        m0_readdatavalid = rd_pending_q & ~rd_owner_q & ~reset;
        m1_readdatavalid = rd_pending_q &  rd_owner_q & ~reset;
        m0_readdata      = tcm_readdata;
        m1_readdata      = tcm_readdata;
    end

    // Next-state for arbitration history and the single outstanding read slot
    always_comb begin
        last_grant_d = last_grant_q;
        rd_owner_d   = rd_owner_q;
        rd_pending_d = (gnt0_s & ~m0_write) | (gnt1_s & ~m1_write);
        if (gnt0_s || gnt1_s) begin
            last_grant_d = gnt1_s;
            rd_owner_d   = gnt1_s;
        end else begin
            last_grant_d = last_grant_q;
            rd_owner_d   = rd_owner_q;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

endmodule
